// File: rtl/zf_backsub_solver_if.sv
// Handshake and data bus of the ZF back-substitution stage.
// The master side feeds Q/R/y and takes x. The slave side is the solver.
interface zf_backsub_solver_if #(
  parameter int W = 32,
  parameter int N = 4
);
  logic             valid_in;
  logic             accept_in;
  logic             accept_out;
  logic             ready_out;
  logic [N*N*W-1:0] Q_matrix;
  logic [N*N*W-1:0] R_matrix;
  logic [N*W-1:0]   y_vector;
  logic [N*W-1:0]   x_vector;
  logic             div_zero;

  modport master (
    output valid_in, accept_in, Q_matrix, R_matrix, y_vector,
    input  accept_out, ready_out, x_vector, div_zero
  );

  modport slave (
    input  valid_in, accept_in, Q_matrix, R_matrix, y_vector,
    output accept_out, ready_out, x_vector, div_zero
  );
endinterface

// File: rtl/zf_backsub_solver.sv
// Zero-forcing solver: computes z = Q^T*y, then back-substitutes R*x = z.
// A single MAC and a single restoring divider are shared by every row.
module zf_backsub_solver #(
  parameter int W    = 32,
  parameter int FRAC = 24,
  parameter int N    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  zf_backsub_solver_if.slave   bus
);
  localparam int AW = 40;
  localparam int PW = 2 * (W - 1);

  typedef enum logic [2:0] {IDLE, QTY, BS_MAC, DIV, DONE} state_t;

  state_t             state;
  logic [W-1:0]       q_m [N*N];
  logic [W-1:0]       r_m [N*N];
  logic [W-1:0]       y_v [N];
  logic [W-1:0]       z_v [N];
  logic [W-1:0]       x_v [N];
  logic [3:0]         cnt;
  logic [1:0]         row;
  logic [1:0]         col;
  logic [4:0]         dcnt;
  logic [AW-1:0]      acc;
  logic [2*W-1:0]     rem;
  logic [2*W-1:0]     dsr;
  logic [W-3:0]       quo;
  logic               div_sat;
  logic               x_sign;

  logic [W-1:0]       op_a;
  logic [W-1:0]       op_b;
  logic [PW-1:0]      prod_full;
  logic [AW-1:0]      prod_ext;
  logic [AW-1:0]      prod_sgn;
  logic [AW-1:0]      acc_qty;
  logic [AW-1:0]      acc_bs;
  logic [AW-1:0]      acc_mag;
  logic [W-1:0]       diag;
  logic [W-2:0]       r_mag;
  logic               rem_ge;
  logic [W-2:0]       q_final;
  logic [W-2:0]       res_mag;
  logic [W-1:0]       x_word;
  logic               div_by_zero;
  logic               div_ovf;

  function automatic logic [W-1:0] to_sm(input logic [AW-1:0] v);
    logic [AW-1:0] mag;
    mag = v[AW-1] ? -v : v;
    if (mag == '0) return '0;
    if (mag > AW'({(W-1){1'b1}})) return {v[AW-1], {(W-1){1'b1}}};
    return {v[AW-1], mag[W-2:0]};
  endfunction

  function automatic logic [AW-1:0] to_acc(input logic [W-1:0] s);
    logic [AW-1:0] mag;
    mag = {{(AW-W+1){1'b0}}, s[W-2:0]};
    return s[W-1] ? -mag : mag;
  endfunction

  // QTY walks Q[k][i]*y[k]; back-substitution walks R[row][col]*x[col].
  always_comb begin
    op_a = '0;
    op_b = '0;
    if (state == QTY) begin
      op_a = q_m[{cnt[1:0], cnt[3:2]}];
      op_b = y_v[cnt[1:0]];
    end else begin
      op_a = r_m[{row, col}];
      op_b = x_v[col];
    end
  end

  assign prod_full = {{(W-1){1'b0}}, op_a[W-2:0]} * {{(W-1){1'b0}}, op_b[W-2:0]};
  assign prod_ext  = AW'(prod_full >> FRAC);
  assign prod_sgn  = (op_a[W-1] ^ op_b[W-1]) ? -prod_ext : prod_ext;
  assign acc_qty   = ((cnt[1:0] == 2'd0) ? '0 : acc) + prod_sgn;
  assign acc_bs    = acc - prod_sgn;

  assign acc_mag     = acc[AW-1] ? -acc : acc;
  assign diag        = r_m[{row, row}];
  assign r_mag       = diag[W-2:0];
  assign div_by_zero = (r_mag == '0);
  // Quotient >= 2^(W-1) after the FRAC shift iff |acc| >= |R| << (W-1-FRAC).
  assign div_ovf     = acc_mag >= ({{(AW-W+1){1'b0}}, r_mag} << (W - 1 - FRAC));
  assign rem_ge      = rem >= dsr;
  assign q_final     = {quo, rem_ge};
  assign res_mag     = div_sat ? '1 : q_final;
  assign x_word      = (res_mag == '0) ? '0 : {x_sign, res_mag};

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bus.accept_out <= 1'b1;
      bus.ready_out  <= 1'b0;
      bus.x_vector   <= '0;
      bus.div_zero   <= 1'b0;
      cnt          <= '0;
      row          <= '0;
      col          <= '0;
      dcnt         <= '0;
      acc          <= '0;
      rem          <= '0;
      dsr          <= '0;
      quo          <= '0;
      div_sat      <= 1'b0;
      x_sign       <= 1'b0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (bus.valid_in) begin
            for (int e = 0; e < N*N; e++) begin
              q_m[e] <= bus.Q_matrix[N*N*W-1-W*e -: W];
              r_m[e] <= bus.R_matrix[N*N*W-1-W*e -: W];
            end
            for (int k = 0; k < N; k++) y_v[k] <= bus.y_vector[N*W-1-W*k -: W];
            bus.accept_out <= 1'b0;
            bus.div_zero   <= 1'b0;
            cnt          <= '0;
            acc          <= '0;
            state        <= QTY;
          end
        end
        QTY: begin
          acc <= acc_qty;
          cnt <= cnt + 4'd1;
          if (cnt[1:0] == 2'd3) z_v[cnt[3:2]] <= to_sm(acc_qty);
          if (cnt == 4'd15) begin
            row   <= 2'd3;
            dcnt  <= '0;
            acc   <= to_acc(to_sm(acc_qty));
            state <= DIV;
          end
        end
        BS_MAC: begin
          acc <= acc_bs;
          if (col == 2'd3) begin
            dcnt  <= '0;
            state <= DIV;
          end else begin
            col <= col + 2'd1;
          end
        end
        DIV: begin
          dcnt <= dcnt + 5'd1;
          if (dcnt == 5'd0) begin
            rem     <= {{(2*W-AW){1'b0}}, acc_mag} << FRAC;
            dsr     <= {{(W+1){1'b0}}, r_mag} << (W - 2);
            quo     <= '0;
            div_sat <= div_by_zero | div_ovf;
            x_sign  <= div_by_zero ? acc[AW-1] : (acc[AW-1] ^ diag[W-1]);
            if (div_by_zero) bus.div_zero <= 1'b1;
          end else begin
            if (rem_ge) rem <= rem - dsr;
            dsr <= dsr >> 1;
            quo <= q_final[W-3:0];
          end
          if (dcnt == 5'd31) begin
            x_v[row] <= x_word;
            if (row == 2'd0) begin
              bus.x_vector  <= {x_word, x_v[1], x_v[2], x_v[3]};
              bus.ready_out <= 1'b1;
              state         <= DONE;
            end else begin
              row   <= row - 2'd1;
              col   <= row;
              acc   <= to_acc(z_v[row - 2'd1]);
              state <= BS_MAC;
            end
          end
        end
        DONE: begin
          if (bus.accept_in) begin
            bus.ready_out  <= 1'b0;
            bus.accept_out <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_zf_backsub_solver.sv
// Self-checking bench for zf_backsub_solver: vector table plus handshake,
// stall and reset sequences, with a queue of expected results.
module tb_zf_backsub_solver;
  localparam logic [31:0] O  = 32'h01000000;
  localparam logic [31:0] T  = 32'h02000000;
  localparam logic [31:0] M  = 32'h81000000;
  localparam logic [31:0] Z  = 32'h00000000;
  localparam logic [511:0] IDM = {O,Z,Z,Z, Z,O,Z,Z, Z,Z,O,Z, Z,Z,Z,O};

  typedef struct {
    logic [511:0] q;
    logic [511:0] r;
    logic [127:0] y;
    logic [127:0] x;
    logic         dz;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  int   cyc = 0;
  int   cap_cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t vecs [6];
  vec_t sb_q [$];

  zf_backsub_solver_if bus ();

  zf_backsub_solver #(.W(32), .FRAC(24), .N(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    int guard = 0;
    while (!bus.accept_out && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.Q_matrix = v.q;
    bus.R_matrix = v.r;
    bus.y_vector = v.y;
    bus.valid_in = 1'b1;
    @(posedge clk); #1;
    cap_cyc = cyc;
    bus.valid_in = 1'b0;
    sb_q.push_back(v);
  endtask

  task automatic wait_result(input string name, input int exp_lat);
    while (!bus.ready_out && (cyc - cap_cyc) < 400) begin
      @(posedge clk); #1;
    end
    check_output($sformatf("%s latency", name), 128'(cyc - cap_cyc), 128'(exp_lat));
  endtask

  task automatic check_result(input string name);
    vec_t v;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", name);
    end else begin
      v = sb_q.pop_front();
      check_output($sformatf("%s x_vector", name), bus.x_vector, v.x);
      check_output($sformatf("%s div_zero", name), 128'(bus.div_zero), 128'(v.dz));
    end
  endtask

  task automatic consume(input string name);
    bus.accept_in = 1'b1;
    @(posedge clk); #1;
    bus.accept_in = 1'b0;
    check_output($sformatf("%s consume ready/accept", name),
                 128'({bus.ready_out, bus.accept_out}), 128'(2'b01));
  endtask

  initial begin
    vec_t dummy;
    int   bad;

    vecs[0] = '{q: IDM, r: IDM, y: {32'h00800000, 32'h80400000, O, Z},
                x: {32'h00800000, 32'h80400000, O, Z}, dz: 1'b0};
    vecs[1] = '{q: IDM, r: {T,Z,Z,Z, Z,T,Z,Z, Z,Z,T,Z, Z,Z,Z,T}, y: {O, O, O, O},
                x: {32'h00800000, 32'h00800000, 32'h00800000, 32'h00800000}, dz: 1'b0};
    vecs[2] = '{q: IDM, r: {O,O,Z,Z, Z,O,O,Z, Z,Z,O,O, Z,Z,Z,O},
                y: {32'h03000000, T, T, O}, x: {T, O, O, O}, dz: 1'b0};
    vecs[3] = '{q: IDM, r: {O,Z,Z,Z, Z,O,Z,Z, Z,Z,Z,Z, Z,Z,Z,O},
                y: {O, 32'h00400000, 32'h80800000, 32'h00200000},
                x: {O, 32'h00400000, 32'hFFFFFFFF, 32'h00200000}, dz: 1'b1};
    vecs[4] = '{q: {Z,O,Z,Z, O,Z,Z,Z, Z,Z,M,Z, Z,Z,Z,O},
                r: {T,Z,M,O, Z,M,Z,Z, Z,Z,O,O, 32'h7F000000,Z,Z,O},
                y: {O, T, O, 32'h00800000},
                x: {Z, M, 32'h81800000, 32'h00800000}, dz: 1'b0};
    vecs[5] = '{q: IDM, r: {32'h00010000,Z,Z,Z, Z,O,Z,Z, Z,Z,O,Z, Z,Z,Z,O},
                y: {O, Z, Z, Z}, x: {32'h7FFFFFFF, Z, Z, Z}, dz: 1'b0};

    reset = 1'b1;
    enable = 1'b1;
    bus.valid_in = 1'b0;
    bus.accept_in = 1'b0;
    bus.Q_matrix = '0;
    bus.R_matrix = '0;
    bus.y_vector = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset accept_out", 128'(bus.accept_out), 128'(1));
    check_output("reset ready_out", 128'(bus.ready_out), 128'(0));
    check_output("reset x_vector", bus.x_vector, 128'(0));
    check_output("reset div_zero", 128'(bus.div_zero), 128'(0));
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      $display("[TB] vector %0d", i);
      apply_stimulus(vecs[i]);
      check_output($sformatf("vec%0d busy accept_out", i), 128'(bus.accept_out), 128'(0));
      wait_result($sformatf("vec%0d", i), 150);
      check_result($sformatf("vec%0d", i));
      consume($sformatf("vec%0d", i));
    end

    // Inputs offered mid-solve must be ignored; result held under backpressure.
    $display("[TB] backpressure and ignored valid_in");
    apply_stimulus(vecs[0]);
    repeat (20) @(posedge clk);
    #1;
    bus.Q_matrix = vecs[1].q;
    bus.R_matrix = vecs[1].r;
    bus.y_vector = vecs[1].y;
    bus.valid_in = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    wait_result("bp", 150);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus.x_vector !== sb_q[0].x || bus.accept_out !== 1'b0 || bus.ready_out !== 1'b1)
        bad++;
    end
    check_output("bp hold cycles bad", 128'(bad), 128'(0));
    check_result("bp");
    consume("bp");

    $display("[TB] enable stall in QTY");
    apply_stimulus(vecs[2]);
    repeat (5) @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    enable = 1'b1;
    wait_result("stall", 160);
    check_result("stall");
    consume("stall");

    $display("[TB] reset during DIV");
    apply_stimulus(vecs[4]);
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    dummy = sb_q.pop_front();
    check_output("abort accept_out", 128'(bus.accept_out), 128'(1));
    check_output("abort ready_out", 128'(bus.ready_out), 128'(0));
    check_output("abort x_vector", bus.x_vector, 128'(0));
    apply_stimulus(vecs[4]);
    wait_result("post-reset", 150);
    check_result("post-reset");
    consume("post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
